// File: rtl/cordic_arbiter.sv
// Round-robin front end for one shared sine/cosine CORDIC core: clamps and issues
// one angle per cycle, tracks the requester ID alongside the core, routes results back.

module cordic_arbiter_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_hit,
  input  logic       i_clamp,
  input  logic [7:0] i_sine,
  input  logic [7:0] i_cosine,
  output logic       o_valid,
  output logic       o_clamped,
  output logic [7:0] o_sine,
  output logic [7:0] o_cosine
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid   <= 1'b0;
      o_clamped <= 1'b0;
      o_sine    <= '0;
      o_cosine  <= '0;
    end else begin
      o_valid <= i_hit;
      if (i_hit) begin
        o_sine    <= i_sine;
        o_cosine  <= i_cosine;
        o_clamped <= i_clamp;
      end
    end
  end
endmodule

module cordic_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 8,
  parameter int ANG_MAX = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_angle,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [8*NREQ-1:0] rsp_sine,
  output logic [8*NREQ-1:0] rsp_cosine,
  output logic [NREQ-1:0]   rsp_clamped,
  output logic [7:0]        cor_in,
  input  logic [7:0]        cor_sine,
  input  logic [7:0]        cor_cosine,
  output logic              busy
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic signed [7:0] LIM  = 8'(ANG_MAX);
  localparam logic signed [7:0] NLIM = -LIM;

  logic [IDW-1:0]              r_rr;
  logic [IDW-1:0]              w_gid;
  logic                        w_gnt;
  logic [NREQ-1:0]             w_oh;
  logic signed [7:0]           w_ang;
  logic signed [7:0]           w_ang_c;
  logic                        w_clamp;
  // Tag pipe has LATENCY+1 entries: the registered cor_in edge plus LATENCY core cycles.
  logic [LATENCY:0]            r_vld_pipe;
  logic [LATENCY:0][IDW-1:0]   r_id_pipe;
  logic [LATENCY:0]            r_cl_pipe;

  function automatic int wrap(input int x);
    return (x >= NREQ) ? x - NREQ : x;
  endfunction

  always_comb begin
    w_gnt = 1'b0;
    w_gid = '0;
    w_oh  = '0;
    for (int off = 0; off < NREQ; off++) begin
      if (!w_gnt && req_valid[wrap(int'(r_rr) + off)]) begin
        w_gnt = 1'b1;
        w_gid = IDW'(wrap(int'(r_rr) + off));
        w_oh[wrap(int'(r_rr) + off)] = 1'b1;
      end
    end
  end

  assign req_ready = rst ? '0 : w_oh;

  always_comb begin
    w_ang   = $signed(req_angle[8*int'(w_gid) +: 8]);
    w_ang_c = w_ang;
    w_clamp = 1'b0;
    if (w_ang > LIM) begin
      w_ang_c = LIM;
      w_clamp = 1'b1;
    end else if (w_ang < NLIM) begin
      w_ang_c = NLIM;
      w_clamp = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr       <= '0;
      cor_in     <= '0;
      r_vld_pipe <= '0;
      r_id_pipe  <= '0;
      r_cl_pipe  <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[LATENCY-1:0], w_gnt};
      r_id_pipe  <= {r_id_pipe[LATENCY-1:0], w_gid};
      r_cl_pipe  <= {r_cl_pipe[LATENCY-1:0], w_gnt & w_clamp};
      cor_in     <= w_gnt ? w_ang_c : 8'sd0;
      if (w_gnt)
        r_rr <= (int'(w_gid) == NREQ-1) ? '0 : w_gid + 1'b1;
    end
  end

  assign busy = |r_vld_pipe;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    cordic_arbiter_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_hit     (r_vld_pipe[LATENCY] && (r_id_pipe[LATENCY] == IDW'(i))),
      .i_clamp   (r_cl_pipe[LATENCY]),
      .i_sine    (cor_sine),
      .i_cosine  (cor_cosine),
      .o_valid   (rsp_valid[i]),
      .o_clamped (rsp_clamped[i]),
      .o_sine    (rsp_sine[8*i +: 8]),
      .o_cosine  (rsp_cosine[8*i +: 8])
    );
  end
endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: ideal-math core model plus a queue-based reference of
// round-robin grants, clamping and in-order response timing.

module tb_cordic_arbiter;
  localparam int N = 4;
  localparam int L = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [8*N-1:0] req_angle;
  logic [N-1:0]  req_ready, rsp_valid, rsp_clamped;
  logic [8*N-1:0] rsp_sine, rsp_cosine;
  logic [7:0]    cor_in, cor_sine, cor_cosine;
  logic          busy;

  cordic_arbiter #(.NREQ(N), .LATENCY(L), .ANG_MAX(100)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_angle(req_angle),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_sine(rsp_sine),
    .rsp_cosine(rsp_cosine), .rsp_clamped(rsp_clamped), .cor_in(cor_in),
    .cor_sine(cor_sine), .cor_cosine(cor_cosine), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int q17(input real x);
    int v;
    v = $rtoi($floor(x * 128.0 + 0.5));
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction
  function automatic int isin(input int a); return q17($sin(a / 64.0)); endfunction
  function automatic int icos(input int a); return q17($cos(a / 64.0)); endfunction

  // Stand-in core: L-cycle delay of cor_in followed by ideal sin/cos.
  logic [7:0] dl [L];
  initial for (int k = 0; k < L; k++) dl[k] = '0;
  always @(posedge clk) begin
    dl[0] <= cor_in;
    for (int k = 1; k < L; k++) dl[k] <= dl[k-1];
  end
  always_comb begin
    cor_sine   = 8'(isin(int'($signed(dl[L-1]))));
    cor_cosine = 8'(icos(int'($signed(dl[L-1]))));
  end

  int checks = 0, failures = 0;
  task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
    checks++;
    if (got - exp > tol || exp - got > tol) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  typedef struct { int id; int ang; bit cl; int due; } ent_t;
  ent_t q[$];
  int   rr = 0, edge_n = 0;
  int   hs[N], hc[N];

  task automatic model_clear();
    q.delete();
    rr = 0;
    for (int i = 0; i < N; i++) begin hs[i] = 0; hc[i] = 0; end
  endtask

  // One clock: drive inputs, predict grant, then check issue and response after the edge.
  task automatic cyc(input logic [N-1:0] v, input logic [8*N-1:0] ang);
    int g, a, exp_rv;
    bit cl;
    ent_t e;
    req_valid = v;
    req_angle = ang;
    g = -1;
    for (int off = 0; off < N; off++)
      if (g < 0 && v[(rr + off) % N]) g = (rr + off) % N;
    @(negedge clk);
    chk("req_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
    @(posedge clk);
    edge_n++;
    a = 0; cl = 0;
    if (g >= 0) begin
      a = int'($signed(ang[8*g +: 8]));
      if (a > 100) begin a = 100; cl = 1; end
      if (a < -100) begin a = -100; cl = 1; end
      q.push_back('{id: g, ang: a, cl: cl, due: edge_n + L + 1});
      rr = (g + 1) % N;
    end
    #1;
    chk("cor_in", int'($signed(cor_in)), a);
    exp_rv = 0;
    if (q.size() > 0 && q[0].due == edge_n) begin
      e = q.pop_front();
      exp_rv = 1 << e.id;
      hs[e.id] = isin(e.ang);
      hc[e.id] = icos(e.ang);
      chk("rsp_clamped", int'(rsp_clamped[e.id]), int'(e.cl));
    end
    chk("rsp_valid", int'(rsp_valid), exp_rv);
    chk("busy", int'(busy), int'(q.size() > 0));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rsp_sine%0d", i), int'($signed(rsp_sine[8*i +: 8])), hs[i], 2);
      chk($sformatf("rsp_cosine%0d", i), int'($signed(rsp_cosine[8*i +: 8])), hc[i], 2);
    end
  endtask

  task automatic do_reset(input int n);
    req_valid = '1;
    rst = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_cor_in", int'(cor_in), 0);
    repeat (n) @(posedge clk);
    edge_n += n;
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc('0, $urandom());
  endtask

  initial begin
    logic [8*N-1:0] ang;
    rst = 1'b1;
    req_valid = '0;
    req_angle = '0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset(3);

    // single request, small angle: sine ~28, cosine ~125 after LATENCY+1 edges
    ang = 32'h0000_000E;
    cyc(4'b0001, ang);
    idle(11);

    // all requesters valid
    repeat (8) cyc(4'b1111, $urandom());
    idle(10);

    // fairness: req 2 always, req 1 joins at cycle 3
    for (int c = 0; c < 10; c++) cyc((c >= 3) ? 4'b0110 : 4'b0100, $urandom());
    idle(10);

    // clamp boundaries
    ang = 32'h0000_0070; cyc(4'b0001, ang);
    ang = 32'h0000_8000; cyc(4'b0010, ang);
    ang = 32'h0063_0000; cyc(4'b0100, ang);
    ang = 32'h9C00_0000; cyc(4'b1000, ang);
    idle(10);

    // reset with requests in flight and rr away from 0
    repeat (3) cyc(4'b1111, $urandom());
    idle(3);
    do_reset(2);
    cyc(4'b1111, $urandom());
    idle(12);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset(1);
      cyc(4'($urandom_range(0, 15)), $urandom());
    end
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
